// File: rtl/vga_text_terminal.sv
// Text terminal: circular 16-bit cell RAM with hardware scroll, ANSI CSI subset, registered display read port.
// Define VGA_TERM_CURSOR_EN for the blinking cursor overlay and CSI ?25h/?25l.
module vga_text_terminal #(
  parameter int         TEXT_COLS      = 100,
  parameter int         TEXT_ROWS      = 75,
  parameter int         RAM_COLS_LOG2  = 7,
  parameter int         RAM_ROWS_LOG2  = 7,
  parameter logic [7:0] DEFAULT_ATTR   = 8'h07,
  parameter int         TAB_WIDTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rd_col,
  input  logic [15:0] rd_row,
  input  logic        rd_valid,
  output logic [7:0]  rd_char,
  output logic [7:0]  rd_attr,
  output logic        rd_cursor,
  input  logic        tty_write,
  input  logic [7:0]  tty_data,
  output logic        tty_busy,
  output logic [15:0] cursor_col,
  output logic [15:0] cursor_row
);
  localparam int CW = RAM_COLS_LOG2;
  localparam int RW = RAM_ROWS_LOG2;
  localparam int AW = CW + RW;
  localparam logic [15:0] COLS = 16'(TEXT_COLS);
  localparam logic [15:0] ROWS = 16'(TEXT_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(TEXT_ROWS - 1);

  typedef enum logic [2:0] {CLR_ALL, IDLE, ESC, CSI, CLR_LINE, CLR_VIS, CLR_EOL} state_t;

  state_t        state_q, state_d;
  logic [15:0]   col_q, col_d, row_q, row_d;
  logic [RW-1:0] scroll_q, scroll_d;
  logic [7:0]    attr_q, attr_d, p0_q, p0_d, p1_q, p1_d;
  logic          pidx_q, pidx_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          rd_hit_q, rd_hit_d;
  logic [15:0]   rd_data_q;
  logic [15:0]   mem [0:2**AW-1];

  logic          we, accept, adv, nl;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata, tab;
  logic [11:0]   acc;
  logic [RW-1:0] cur_phys, bot_phys, vis_phys, rd_phys;

  function automatic logic [7:0] sgr(input logic [7:0] a, input logic [7:0] p);
    logic [7:0] f;
    f = p - 8'd30;
    if (p == 8'd0) return DEFAULT_ATTR;
    if (p >= 8'd30 && p <= 8'd37) return {a[7:3], f[2:0]};
    if (p >= 8'd40 && p <= 8'd47) return {a[7], p[2:0], a[3:0]};
    return a;
  endfunction

  // 1-based CSI coordinate clamped into [0, lim-1]
  function automatic logic [15:0] clamp_pos(input logic [7:0] p, input logic [15:0] lim);
    logic [15:0] v;
    v = {8'd0, p};
    if (v == 16'd0) v = 16'd1;
    if (v > lim) v = lim;
    return v - 16'd1;
  endfunction

`ifdef VGA_TERM_CURSOR_EN
  logic [23:0] blink_q, blink_d;
  logic        vis_q, vis_d, qm_q, qm_d, rd_cursor_q, rd_cursor_d;
  assign rd_cursor = rd_cursor_q;
`else
  assign rd_cursor = 1'b0;
`endif

  assign tty_busy   = !(state_q == IDLE || state_q == ESC || state_q == CSI);
  assign accept     = tty_write && !tty_busy;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign rd_char    = rd_hit_q ? rd_data_q[7:0]  : 8'd0;
  assign rd_attr    = rd_hit_q ? rd_data_q[15:8] : 8'd0;
  assign cur_phys   = RW'(row_q) + scroll_q;
  assign bot_phys   = LAST_ROW + scroll_q;
  assign vis_phys   = clr_q[AW-1:CW] + scroll_q;
  assign rd_phys    = rd_row[RW-1:0] + scroll_q;
  assign rd_hit_d   = rd_valid && rd_col < COLS && rd_row < ROWS;

  always_comb begin
    state_d = state_q; col_d = col_q; row_d = row_q; scroll_d = scroll_q;
    attr_d = attr_q; p0_d = p0_q; p1_d = p1_q; pidx_d = pidx_q; clr_d = clr_q;
    we = 1'b0; waddr = {cur_phys, col_q[CW-1:0]}; wdata = {attr_q, tty_data};
    adv = 1'b0; nl = 1'b0;
    acc = {4'd0, (pidx_q ? p1_q : p0_q)} * 12'd10 + {8'd0, tty_data[3:0]};
    tab = ((col_q >> TAB_WIDTH_LOG2) + 16'd1) << TAB_WIDTH_LOG2;
`ifdef VGA_TERM_CURSOR_EN
    blink_d = blink_q + 24'd1; vis_d = vis_q; qm_d = qm_q;
    rd_cursor_d = rd_valid && rd_col == col_q && rd_row == row_q && blink_q[23] && vis_q;
`endif
    case (state_q)
      CLR_ALL: begin
        we = 1'b1; waddr = clr_q; wdata = {DEFAULT_ATTR, 8'h20};
        clr_d = clr_q + 1'b1;
        if (&clr_q) begin state_d = IDLE; col_d = '0; row_d = '0; end
      end
      CLR_LINE, CLR_EOL: begin
        we = 1'b1; wdata = {attr_q, 8'h20};
        waddr = {(state_q == CLR_LINE) ? bot_phys : cur_phys, clr_q[CW-1:0]};
        clr_d = clr_q + 1'b1;
        if (&clr_q[CW-1:0]) state_d = IDLE;
      end
      CLR_VIS: begin
        we = 1'b1; wdata = {attr_q, 8'h20}; waddr = {vis_phys, clr_q[CW-1:0]};
        clr_d = clr_q + 1'b1;
        if (clr_q[AW-1:CW] == LAST_ROW && &clr_q[CW-1:0]) state_d = IDLE;
      end
      IDLE: if (accept) begin
        case (tty_data)
          8'h0A: nl = 1'b1;
          8'h0D: col_d = '0;
          8'h08: col_d = (col_q == '0) ? '0 : col_q - 16'd1;
          8'h09: col_d = (tab >= COLS) ? COLS - 16'd1 : tab;
          8'h1B: state_d = ESC;
          default: begin we = 1'b1; adv = 1'b1; end
        endcase
      end
      ESC: if (accept) begin
        case (tty_data)
          "[": begin
            p0_d = '0; p1_d = '0; pidx_d = 1'b0; state_d = CSI;
`ifdef VGA_TERM_CURSOR_EN
            qm_d = 1'b0;
`endif
          end
          "c": begin state_d = CLR_ALL; clr_d = '0; attr_d = DEFAULT_ATTR; scroll_d = '0; end
          default: begin we = 1'b1; adv = 1'b1; state_d = IDLE; end
        endcase
      end
      CSI: if (accept) begin
        state_d = IDLE;
        if (tty_data >= "0" && tty_data <= "9") begin
          state_d = CSI;
          if (pidx_q) p1_d = (acc > 12'd255) ? 8'd255 : acc[7:0];
          else        p0_d = (acc > 12'd255) ? 8'd255 : acc[7:0];
        end else begin
          case (tty_data)
            ";": begin pidx_d = 1'b1; state_d = CSI; end
            "H", "f": begin row_d = clamp_pos(p0_q, ROWS); col_d = clamp_pos(p1_q, COLS); end
            "J": if (p0_q == 8'd2) begin state_d = CLR_VIS; clr_d = '0; end
            "K": begin state_d = CLR_EOL; clr_d = {{RW{1'b0}}, col_q[CW-1:0]}; end
            "m": attr_d = pidx_q ? sgr(sgr(attr_q, p0_q), p1_q) : sgr(attr_q, p0_q);
`ifdef VGA_TERM_CURSOR_EN
            "?": begin qm_d = 1'b1; state_d = CSI; end
            "h", "l": if (qm_q && p0_q == 8'd25) vis_d = (tty_data == "h");
`endif
            default: ;
          endcase
        end
      end
      default: state_d = CLR_ALL;
    endcase
    if (adv) begin
      if (col_q == COLS - 16'd1) begin col_d = '0; nl = 1'b1; end
      else col_d = col_q + 16'd1;
    end
    // bottom-row newline scrolls the ring and blanks the row that becomes visible
    if (nl) begin
      if (row_q == ROWS - 16'd1) begin scroll_d = scroll_q + 1'b1; state_d = CLR_LINE; clr_d = '0; end
      else row_d = row_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= mem[{rd_phys, rd_col[CW-1:0]}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_ALL; col_q <= '0; row_q <= '0; scroll_q <= '0;
      attr_q <= DEFAULT_ATTR; p0_q <= '0; p1_q <= '0; pidx_q <= 1'b0;
      clr_q <= '0; rd_hit_q <= 1'b0;
`ifdef VGA_TERM_CURSOR_EN
      blink_q <= '0; vis_q <= 1'b1; qm_q <= 1'b0; rd_cursor_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; col_q <= col_d; row_q <= row_d; scroll_q <= scroll_d;
      attr_q <= attr_d; p0_q <= p0_d; p1_q <= p1_d; pidx_q <= pidx_d;
      clr_q <= clr_d; rd_hit_q <= rd_hit_d;
`ifdef VGA_TERM_CURSOR_EN
      blink_q <= blink_d; vis_q <= vis_d; qm_q <= qm_d; rd_cursor_q <= rd_cursor_d;
`endif
    end
  end
endmodule

// File: tb/tb_vga_text_terminal.sv
// Directed bench for vga_text_terminal: clears, printing, scroll, CSI cursor/erase/colour, reset mid-clear.
module tb_vga_text_terminal;
  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] rd_col = '0, rd_row = '0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_char, rd_attr;
  logic        rd_cursor;
  logic        tty_write = 1'b0;
  logic [7:0]  tty_data = '0;
  logic        tty_busy;
  logic [15:0] cursor_col, cursor_row;

  int checks = 0, failures = 0;

  vga_text_terminal dut (
    .clk(clk), .reset(reset), .rd_col(rd_col), .rd_row(rd_row), .rd_valid(rd_valid),
    .rd_char(rd_char), .rd_attr(rd_attr), .rd_cursor(rd_cursor),
    .tty_write(tty_write), .tty_data(tty_data), .tty_busy(tty_busy),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (tty_busy && n < 30000) begin @(posedge clk); #1; n++; end
    if (tty_busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    wait_idle(n);
    tty_data = b; tty_write = 1'b1;
    @(posedge clk); #1;
    tty_write = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic csi(input string s);
    send(8'h1B); send("["); send_str(s);
  endtask

  task automatic rd(input int c, input int r, output logic [7:0] ch, output logic [7:0] at);
    rd_col = 16'(c); rd_row = 16'(r); rd_valid = 1'b1;
    @(posedge clk); #1;
    ch = rd_char; at = rd_attr; rd_valid = 1'b0;
  endtask

  task automatic chk_cell(input string tag, input int c, input int r, input logic [7:0] ec, input logic [7:0] ea);
    logic [7:0] ch, at;
    rd(c, r, ch, at);
    chk({tag, "_char"}, {24'd0, ch}, {24'd0, ec});
    chk({tag, "_attr"}, {24'd0, at}, {24'd0, ea});
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, {16'd0, cursor_col}, 32'(c));
    chk({tag, "_row"}, {16'd0, cursor_row}, 32'(r));
  endtask

  initial begin
    int n;
    logic [7:0] ch, at;
    #1 reset = 1'b1;
    #12;
    chk("rst_busy", {31'd0, tty_busy}, 32'd1);
    chk("rst_char", {24'd0, rd_char}, 32'd0);
    chk("rst_attr", {24'd0, rd_attr}, 32'd0);
    chk("rst_cursor", {31'd0, rd_cursor}, 32'd0);
    chk_cur("rst_pos", 0, 0);
    @(negedge clk) reset = 1'b0;
    wait_idle(n);
    chk("clr_all_cycles", 32'(n), 32'd16384);
    chk_cell("blank00", 0, 0, 8'h20, 8'h07);
    chk_cell("blank_br", 99, 74, 8'h20, 8'h07);
    chk_cell("blank_mid", 50, 37, 8'h20, 8'h07);
    chk_cell("oob_col", 100, 0, 8'h00, 8'h00);
    chk_cell("oob_row", 0, 75, 8'h00, 8'h00);
    rd_col = 0; rd_row = 0; @(posedge clk); #1;
    chk("novalid_attr", {24'd0, rd_attr}, 32'd0);

    send_str("AB\r\nC");
    chk_cell("A", 0, 0, "A", 8'h07);
    chk_cell("B", 1, 0, "B", 8'h07);
    chk_cell("C", 0, 1, "C", 8'h07);
    chk_cur("abc_pos", 1, 1);

    // scroll: 75 newlines from row 0, bytes held during the line clear must be dropped
    csi("H");
    chk_cur("home", 0, 0);
    for (int i = 0; i < 74; i++) send(8'h0A);
    chk_cur("row74", 0, 74);
    send(8'h0A);
    chk("busy_after_nl", {31'd0, tty_busy}, 32'd1);
    tty_data = "Q"; tty_write = 1'b1;
    wait_idle(n);
    tty_write = 1'b0;
    chk("clr_line_cycles", 32'(n), 32'd128);
    chk_cur("scroll_pos", 0, 74);
    chk_cell("scrolled_C", 0, 0, "C", 8'h07);
    chk_cell("row74_c0", 0, 74, 8'h20, 8'h07);
    chk_cell("row74_c99", 99, 74, 8'h20, 8'h07);
    chk_cell("row73_c0", 0, 73, 8'h20, 8'h07);

    csi("31;44mX");
    chk_cell("X", 0, 74, "X", 8'h41);
    csi("0mY");
    chk_cell("Y", 1, 74, "Y", 8'h07);

    csi("10;5H");
    chk_cur("h10_5", 4, 9);
    send("Z");
    chk_cell("Z", 4, 9, "Z", 8'h07);
    csi("999;999H");
    chk_cur("h_sat", 99, 74);

    csi("5;1H"); send(8'h08);
    chk_cur("bs_at0", 0, 4);
    send(8'h09);
    chk_cur("tab8", 8, 4);
    csi("5;98H"); send(8'h09);
    chk_cur("tab_clamp", 99, 4);

    csi("2J");
    wait_idle(n);
    chk("clr_vis_cycles", 32'(n), 32'd9600);
    chk_cur("j_pos", 99, 4);
    chk_cell("Z_erased", 4, 9, 8'h20, 8'h07);

    csi("3;1H"); send_str("abcdef");
    csi("3;3H"); csi("K");
    wait_idle(n);
    chk_cell("eol_keep", 1, 2, "b", 8'h07);
    chk_cell("eol_clr2", 2, 2, 8'h20, 8'h07);
    chk_cell("eol_clr5", 5, 2, 8'h20, 8'h07);
    chk_cur("eol_pos", 2, 2);

    // reset during a line clear
    csi("32m"); csi("75;1H"); send(8'h0A);
    repeat (20) @(posedge clk);
    rd_col = 0; rd_row = 0; rd_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_attr", {24'd0, rd_attr}, 32'h07);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, tty_busy}, 32'd1);
    chk("mid_rst_attr", {24'd0, rd_attr}, 32'd0);
    chk_cur("mid_rst_pos", 0, 0);
    rd_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    wait_idle(n);
    chk("clr_all2_cycles", 32'(n), 32'd16384);
    send("R");
    chk_cell("R_default_attr", 0, 0, "R", 8'h07);
    chk_cur("R_pos", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_text_terminal.md
Name: vga_text_terminal

Overview:
- Parametrised successor to the team's 8-bit TTY text buffer.
- Stores 16-bit cells (char + colour attribute) in a circular RAM with hardware scroll.
- Accepts a byte stream with a busy handshake and interprets a subset of ANSI CSI escapes (cursor position, erase, colour).
- A registered read port feeds the VGA character/font stage on the same clock.

Parameters:
- TEXT_COLS, 100, visible columns.
- TEXT_ROWS, 75, visible rows.
- RAM_COLS_LOG2, 7, log2 of RAM row pitch; 2**RAM_COLS_LOG2 >= TEXT_COLS.
- RAM_ROWS_LOG2, 7, log2 of RAM rows; 2**RAM_ROWS_LOG2 >= TEXT_ROWS+1.
- DEFAULT_ATTR, 8'h07, attribute after reset and after SGR 0: bg[6:4], fg[2:0], bit7/bit3 reserved 0.
- TAB_WIDTH_LOG2, 3, tab stop spacing is 2**TAB_WIDTH_LOG2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- rd_col  in  16  display column.
- rd_row  in  16  display row (0 = top visible row).
- rd_valid  in  1  display read enable.
- rd_char  out  8  character at (rd_col, rd_row), 1-cycle latency.
- rd_attr  out  8  attribute of that cell, 1-cycle latency.
- rd_cursor  out  1  cell is under cursor (optional feature only, else tied 0).
- tty_write  in  1  byte strobe.
- tty_data  in  8  byte.
- tty_busy  out  1  byte not accepted while high.
- cursor_col  out  16  current cursor column.
- cursor_row  out  16  current cursor row.

Behaviour:
- Reset (async): tty_busy=1, rd_char=0, rd_attr=0, rd_cursor=0, cursor=(0,0), scroll=0, attr=DEFAULT_ATTR, state=CLR_ALL.
- Read port: rd_char/rd_attr <= rd_valid && rd_col<TEXT_COLS && rd_row<TEXT_ROWS ? cell[(rd_row+scroll) mod 2**RAM_ROWS_LOG2][rd_col] : 0.
- Handshake: a byte is consumed on any clk edge with tty_write=1 and tty_busy=0. Bytes presented while busy are ignored; the sender holds them.
- CLR_ALL: writes space/DEFAULT_ATTR to every RAM cell, one per clk (2**(RAM_COLS_LOG2+RAM_ROWS_LOG2) cycles). Then cursor=(0,0), busy=0, go to IDLE.
- IDLE, byte handling:
  - 0x0A: newline.
  - 0x0D: col=0.
  - 0x08: col=max(col-1,0).
  - 0x09: col = next tab stop; if >= TEXT_COLS, col=TEXT_COLS-1.
  - 0x1B: go to ESC.
  - Any other byte: write {attr,byte} at cursor, then advance.
- Advance: col+1; at col=TEXT_COLS-1 wrap to col 0 and do a newline.
- Newline: row+1; at row=TEXT_ROWS-1, scroll+1 (mod RAM rows), row unchanged, enter CLR_LINE.
- CLR_LINE: busy=1, writes spaces/current attr across the full RAM row now at visible row TEXT_ROWS-1 (2**RAM_COLS_LOG2 cycles), then IDLE.
- ESC state:
  - '[' clears p0=p1=0, sets pidx=0, goes to CSI.
  - 'c' does a full reset: CLR_ALL, attr=DEFAULT_ATTR.
  - Any other byte is printed as a normal char, then IDLE.
- CSI state:
  - Digits: p[pidx]=p*10+digit, saturating at 255.
  - ';': pidx=1; a further ';' is ignored.
  - 'H'/'f': row=min(max(p0,1),TEXT_ROWS)-1, col=min(max(p1,1),TEXT_COLS)-1.
  - 'J' with p0=2: CLR_VIS, clears visible rows only (TEXT_ROWS*2**RAM_COLS_LOG2 cycles, busy=1); cursor unchanged.
  - 'K': clear from cursor to end of line (busy during clear).
  - 'm', processed per param p0 then p1 (p1 only if pidx=1):
    - 0 = DEFAULT_ATTR.
    - 30..37 = fg.
    - 40..47 = bg.
    - Others ignored.
  - Any other final byte: discard sequence.
  - After a final byte: IDLE, or the clear state it started.
- tty_busy is 0 in IDLE/ESC/CSI and 1 in every clear state. busy rises the cycle after the accepting edge that triggers a clear.
- Display reads during clears return whatever is in RAM; no stall.
- Reset asserted mid-clear aborts the clear and restarts CLR_ALL.

Optional Feature:
- Macro: VGA_TERM_CURSOR_EN.
- Defined: rd_cursor is registered alongside rd_char. It is 1 when rd_valid, (rd_col,rd_row)==cursor, and a 24-bit blink counter bit 23 = 1. The counter is reset to 0 by reset.
  - CSI "?25l" / "?25h" hide/show the cursor; '?' is accepted in CSI state, and the reset default is shown.
- Undefined: rd_cursor constant 0. No counter. '?' terminates the CSI sequence as an unknown final byte.

Test Plan:
- Reset, wait for busy=0 -> busy stays high exactly 16384 cycles (defaults). Every visible read returns char 0x20, attr 0x07.
- Write "AB\r\nC" -> cells (0,0)='A', (1,0)='B', (0,1)='C'; cursor=(1,1).
- Write 75 newlines from row 0 -> scroll=1 after the 75th. Row 74 reads all spaces. Former row 1 content now reads at row 0; busy high 128 cycles.
- Write ESC"[31;44mX" -> X stored with attr 8'h41. Then ESC"[0mY" -> Y attr 8'h07.
- Write ESC"[10;5H" then 'Z' -> Z at col 4, row 9. ESC"[999;999H" -> cursor=(99,74).
- Assert reset mid-CLR_LINE -> all outputs return to reset values asynchronously and a full CLR_ALL follows. Bytes written while busy are not stored.
